dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Two-requester arbiter and sequencer for the single-port synchronous data memory (1-cycle read latency, word-indexed, no byte enables). It shares the memory between the load/store unit (port 0) and a debug/DMA port (port 1). Partial-word stores are converted into a read-modify-write sequence. It sits between the LSU/debug logic and the dmem instance, and drives the dmem's `addr`/`wdata`/`we` and consumes its `rdata`.

## Interface
- `ADDR_LEN`, 32, requester byte-address width and memory address width.
- `DATA_LEN`, 32, data width; must be 32 (4 byte lanes).
- `STARVE_LIMIT`, 4, consecutive denied cycles of port 1 before it is forced to win.

Ports:
- `clk`  in  1  single clock, all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  request valid; held with its payload stable until the `gnt` cycle.
- `p0_we`, `p1_we`  in  1  1 = store, 0 = load.
- `p0_addr`, `p1_addr`  in  ADDR_LEN  byte address; bits [1:0] ignored.
- `p0_wdata`, `p1_wdata`  in  DATA_LEN  store data.
- `p0_be`, `p1_be`  in  4  store byte enables; ignored for loads.
- `p0_gnt`, `p1_gnt`  out  1  combinational; request accepted this cycle.
- `p0_rvalid`, `p1_rvalid`  out  1  registered; load data valid.
- `p0_rdata`, `p1_rdata`  out  DATA_LEN  equals `mem_rdata` while the matching rvalid is 1, else 0.
- `mem_addr`  out  ADDR_LEN  word index, `{2'b00, addr[ADDR_LEN-1:2]}`.
- `mem_wdata`  out  DATA_LEN  write data to the dmem.
- `mem_we`  out  1  write enable to the dmem.
- `mem_rdata`  in  DATA_LEN  dmem read data, valid the cycle after the address is presented.

## Operation
- FSM states:
  - IDLE: grants are possible.
  - RMW: second cycle of a partial store; no grant is issued.
- Arbitration in IDLE:
  - Port 0 has fixed priority.
  - Port 1 wins instead when `starve_cnt == STARVE_LIMIT` and `p1_req` is 1.
  - At most one gnt is high per cycle.
- `starve_cnt`:
  - Increments, saturating at STARVE_LIMIT, each cycle that `p1_req` = 1 and `p1_gnt` = 0, including RMW cycles.
  - Clears when `p1_gnt` = 1 or `p1_req` = 0.
- Granted load: `mem_addr` is driven from the winner and `mem_we` = 0. The winner's rvalid is 1 in the next cycle.
- Granted store, `be == 4'hF`: single-cycle write in the grant cycle. `mem_we` = 1, `mem_wdata` = wdata.
- Granted store, `be == 4'h0`: accepted as a no-op, with `mem_we` = 0 and no state change.
- Granted store, any other `be` (read-modify-write):
  - Grant cycle: issues a read (`mem_we` = 0), latches addr/wdata/be, and moves to RMW.
  - RMW cycle: drives the latched `mem_addr` with `mem_we` = 1. `mem_wdata` byte i is `wdata[8i+7:8i]` if `be[i]`, else `mem_rdata[8i+7:8i]`. Returns to IDLE.
- No gnt in RMW. A new request is granted at the earliest in the cycle after RMW.
- When nothing is granted in IDLE: `mem_we` = 0 and `mem_addr` holds its last value (registered copy).

## Timing
- Load latency: grant at cycle N, data and rvalid at N+1. Back-to-back loads give one per cycle; rvalid may be high on one port while the other port is granted.
- Full-word store: occupies 1 cycle, and the memory is written at the end of the grant cycle.
- Partial store: occupies 2 cycles, and the memory is written at the end of the RMW cycle.
- A load to the same word granted in the cycle right after RMW returns the merged data (dmem read-after-write across cycles).
- During reset and the first cycle after it:
  - State is IDLE, `starve_cnt` = 0, and both rvalid = 0.
  - Both gnt are forced to 0, `mem_we` = 0, and `mem_addr` = 0.
- Reset asserted while in RMW: the pending write is dropped, `mem_we` = 0, and the FSM returns to IDLE. The requester already holds its gnt, so the store is lost. This is accepted behaviour.

## Test plan
- **Reset:** assert `reset` with both req = 1 → both gnt = 0, rvalid = 0, `mem_we` = 0; the first grant comes the cycle after deassert.
- **Full store then load:** p0 stores `0xDEADBEEF` to addr `0x40` with be F, then loads `0x40` → `mem_we` pulses 1 cycle with `mem_addr` = `0x10`; `p0_rvalid` arrives 1 cycle after the load gnt with rdata `0xDEADBEEF`.
- **Partial store:** after the above, p1 stores `0x000000AA` to `0x40` with be `4'b0001` → 2-cycle occupancy, no gnt in the RMW cycle; a following load reads `0xDEADBEAA`.
- **Starvation:** p0 and p1 both request continuously with loads → p0 is granted 4 cycles, p1 is granted on the 5th cycle, then p0 resumes.
- **Concurrent pending:** p0 and p1 both request during an RMW cycle → neither is granted; p0 is granted the next cycle.
- **No-op and reset mid-RMW:** a store with be `0` gets a gnt with `mem_we` = 0 and memory unchanged. Reset during RMW → no write occurs and the word keeps its old value.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port synchronous dmem between the LSU (port 0) and the debug/DMA port (port 1).
// Partial-word stores become a read followed by a merged write.
module dmem_port_arbiter #(
   parameter int ADDR_LEN     = 32,
   parameter int DATA_LEN     = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                p0_req,
   input  logic                p0_we,
   input  logic [ADDR_LEN-1:0] p0_addr,
   input  logic [DATA_LEN-1:0] p0_wdata,
   input  logic [3:0]          p0_be,
   input  logic                p1_req,
   input  logic                p1_we,
   input  logic [ADDR_LEN-1:0] p1_addr,
   input  logic [DATA_LEN-1:0] p1_wdata,
   input  logic [3:0]          p1_be,
   output logic                p0_gnt,
   output logic                p1_gnt,
   output logic                p0_rvalid,
   output logic                p1_rvalid,
   output logic [DATA_LEN-1:0] p0_rdata,
   output logic [DATA_LEN-1:0] p1_rdata,
   output logic [ADDR_LEN-1:0] mem_addr,
   output logic [DATA_LEN-1:0] mem_wdata,
   output logic                mem_we,
   input  logic [DATA_LEN-1:0] mem_rdata
);
   localparam int CntW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {IDLE, RMW} state_t;

   state_t              state;
   logic [CntW-1:0]     starveCnt;
   logic                initDone;
   logic                rvalid0;
   logic                rvalid1;
   logic [ADDR_LEN-1:0] addrHold;
   logic [ADDR_LEN-1:0] rmwAddr;
   logic [DATA_LEN-1:0] rmwWdata;
   logic [3:0]          rmwBe;

   logic                canGrant;
   logic                starved;
   logic                p0Wins;
   logic                p1Wins;
   logic                anyGnt;
   logic                selWe;
   logic [DATA_LEN-1:0] selWdata;
   logic [3:0]          selBe;
   logic [ADDR_LEN-1:0] selWord;
   logic                partialStore;
   logic                unusedAddrBits;

   assign unusedAddrBits = &{1'b0, p0_addr[1:0], p1_addr[1:0]};

   // Port 0 wins by default; port 1 takes over once it has waited STARVE_LIMIT cycles.
   always_comb begin
      canGrant     = !reset && initDone && (state == IDLE);
      starved      = (starveCnt == CntW'(STARVE_LIMIT));
      p1Wins       = canGrant && p1_req && (!p0_req || starved);
      p0Wins       = canGrant && p0_req && !p1Wins;
      anyGnt       = p0Wins || p1Wins;
      selWe        = p1Wins ? p1_we    : p0_we;
      selWdata     = p1Wins ? p1_wdata : p0_wdata;
      selBe        = p1Wins ? p1_be    : p0_be;
      selWord      = p1Wins ? {2'b00, p1_addr[ADDR_LEN-1:2]} : {2'b00, p0_addr[ADDR_LEN-1:2]};
      partialStore = anyGnt && selWe && (selBe != 4'hF) && (selBe != 4'h0);
   end

   assign p0_gnt    = p0Wins;
   assign p1_gnt    = p1Wins;
   assign p0_rvalid = rvalid0;
   assign p1_rvalid = rvalid1;
   assign p0_rdata  = rvalid0 ? mem_rdata : '0;
   assign p1_rdata  = rvalid1 ? mem_rdata : '0;

   always_comb begin
      mem_addr  = addrHold;
      mem_we    = 1'b0;
      mem_wdata = selWdata;
      if (reset) begin
         mem_addr = '0;
      end else if (state == RMW) begin
         mem_addr = rmwAddr;
         mem_we   = 1'b1;
         for (int i = 0; i < 4; i++) begin
            mem_wdata[8*i +: 8] = rmwBe[i] ? rmwWdata[8*i +: 8] : mem_rdata[8*i +: 8];
         end
      end else if (anyGnt) begin
         mem_addr = selWord;
         mem_we   = selWe && (selBe == 4'hF);
      end
   end

   // initDone keeps grants off for the first cycle after reset is released.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         starveCnt <= '0;
         initDone  <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         addrHold  <= '0;
         rmwAddr   <= '0;
         rmwWdata  <= '0;
         rmwBe     <= '0;
      end else begin
         initDone <= 1'b1;
         addrHold <= mem_addr;
         rvalid0  <= p0Wins && !p0_we;
         rvalid1  <= p1Wins && !p1_we;
         if (p1_req && !p1Wins) begin
            starveCnt <= starved ? starveCnt : starveCnt + CntW'(1);
         end else begin
            starveCnt <= '0;
         end
         case (state)
            IDLE: begin
               if (partialStore) begin
                  state    <= RMW;
                  rmwAddr  <= selWord;
                  rmwWdata <= selWdata;
                  rmwBe    <= selBe;
               end
            end
            RMW: state <= IDLE;
         endcase
      end
   end
endmodule
